// File: rtl/sha1_pad.sv
// SHA-1 message padder: packs 32-bit words into 512-bit blocks, appends the 0x80 marker, zero fill and length.
// Optional SHA1_PAD_BLKCNT_EN adds a 16-bit wrapping count of block handshakes on output blk_count.
module sha1_pad #(
  parameter int LEN_WIDTH = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         block_valid,
  input  logic         block_ready,
  output logic [511:0] block_data,
  output logic         block_last,
  output logic         busy
`ifdef SHA1_PAD_BLKCNT_EN
  ,output logic [15:0] blk_count
`endif
);

  // state  | meaning
  // ACCEPT | collecting message words into the block buffer
  // PAD    | one cycle: marker, zero fill, length or defer length to EXTRA
  // EMIT   | block presented, waiting for consumer handshake
  // EXTRA  | one cycle: build the trailing length-only block
  typedef enum logic [1:0] {ACCEPT, PAD, EMIT, EXTRA} state_t;

  state_t               state, state_next;
  logic [31:0]          words [16];
  logic [3:0]           word_idx;
  logic [3:0]           last_idx;
  logic [1:0]           last_bytes;
  logic [LEN_WIDTH-1:0] bit_cnt;
  logic                 pending;
  logic                 carry;
  logic                 last_r;
  logic                 accept;
  logic                 handshake;
  logic                 last_full;
  logic [4:0]           mark_idx;
  logic [63:0]          len64;
  logic [31:0]          keep_mask;
  logic [31:0]          marker;
  logic [5:0]           add_bits;

  assign accept     = in_valid & in_ready;
  assign handshake  = block_valid & block_ready;
  assign last_full  = (last_bytes == 2'd0);
  assign mark_idx   = {1'b0, last_idx} + {4'b0, last_full};
  assign len64      = 64'(bit_cnt);
  assign block_last = last_r;
  assign busy       = (state != ACCEPT) || (word_idx != 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCEPT;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    block_valid = 1'b0;
    case (state)
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_last)                 state_next = PAD;
          else if (word_idx == 4'd15)  state_next = EMIT;
        end
      end
      PAD:   state_next = EMIT;
      EMIT: begin
        block_valid = 1'b1;
        if (block_ready) state_next = pending ? EXTRA : ACCEPT;
      end
      EXTRA: state_next = EMIT;
      default: state_next = ACCEPT;
    endcase
  end

  // Final-word byte mask, length increment and marker placement.
  always_comb begin
    keep_mask = 32'hFFFF_FFFF;
    add_bits  = 6'd32;
    if (in_last) begin
      case (in_bytes)
        2'd1:    keep_mask = 32'hFF00_0000;
        2'd2:    keep_mask = 32'hFFFF_0000;
        2'd3:    keep_mask = 32'hFFFF_FF00;
        default: keep_mask = 32'hFFFF_FFFF;
      endcase
      if (in_bytes != 2'd0) add_bits = {1'b0, in_bytes, 3'b000};
    end
    case (last_bytes)
      2'd1:    marker = 32'h0080_0000;
      2'd2:    marker = 32'h0000_8000;
      2'd3:    marker = 32'h0000_0080;
      default: marker = 32'h8000_0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) words[i] <= '0;
      word_idx   <= '0;
      last_idx   <= '0;
      last_bytes <= '0;
      bit_cnt    <= '0;
      pending    <= 1'b0;
      carry      <= 1'b0;
      last_r     <= 1'b0;
    end else begin
      case (state)
        ACCEPT: begin
          if (accept) begin
            words[word_idx] <= in_data & keep_mask;
            word_idx        <= word_idx + 4'd1;
            bit_cnt         <= bit_cnt + LEN_WIDTH'(add_bits);
            if (in_last) begin
              last_idx   <= word_idx;
              last_bytes <= in_bytes;
            end
          end
        end
        PAD: begin
          // Later assignments override the zero fill for marker and length words.
          for (int i = 0; i < 16; i++)
            if (5'(i) > {1'b0, last_idx}) words[i] <= '0;
          if (!last_full)              words[last_idx] <= words[last_idx] | marker;
          else if (last_idx != 4'd15)  words[last_idx + 4'd1] <= marker;
          if (mark_idx <= 5'd13) begin
            words[14] <= len64[63:32];
            words[15] <= len64[31:0];
            last_r    <= 1'b1;
          end else begin
            last_r  <= 1'b0;
            pending <= 1'b1;
            carry   <= (mark_idx == 5'd16);
          end
        end
        EMIT: begin
          if (handshake) begin
            pending <= 1'b0;
            last_r  <= 1'b0;
            if (last_r) begin
              bit_cnt  <= '0;
              word_idx <= '0;
            end
          end
        end
        EXTRA: begin
          for (int i = 1; i < 14; i++) words[i] <= '0;
          words[0]  <= carry ? 32'h8000_0000 : 32'h0;
          words[14] <= len64[63:32];
          words[15] <= len64[31:0];
          last_r    <= 1'b1;
          carry     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    block_data = '0;
    for (int i = 0; i < 16; i++) block_data[32*i +: 32] = words[i];
  end

`ifdef SHA1_PAD_BLKCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          blk_count <= '0;
    else if (handshake) blk_count <= blk_count + 16'd1;
  end
`endif

endmodule
